// File: rtl/pa_fmau_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pa_fmau_pipe_ctrl_pkg
// Shared definitions for the FMAU pipeline controller: controller FSM state
// encoding, pipeline stage count and the width of the warm-up counter.
// -----------------------------------------------------------------------------
package pa_fmau_pipe_ctrl_pkg;

    // EX1 (issue), EX2 (frac shift), EX3 (add/norm)
    localparam int unsigned FMAU_STAGE_NUM = 3;

    // Warm-up counter width; covers WARM_UP_CYCLES of 1..15
    localparam int unsigned FMAU_WARM_CNT_W = 4;

    typedef enum logic {
        FMAU_WARM = 1'b0,
        FMAU_RUN  = 1'b1
    } fmau_state_e;

endpackage

// File: rtl/pa_fmau_stage_vld.sv
// -----------------------------------------------------------------------------
// pa_fmau_stage_vld
// One FMAU pipeline stage bookkeeping register: valid bit plus a payload
// (MAC flag and/or destination tag). Used for the EX2 and EX3 stages.
// Ports:
//   clk_i    clock                rst_b_i  async reset, active low
//   load_i   new op enters stage  drain_i  current op leaves stage
//   flush_i  kill stage content   pld_i    payload of the entering op
//   vld_o    stage holds an op    pld_o    payload of the held op
// Priority on the valid bit: flush > load > drain > hold. The payload only
// changes on load so a flushed or drained stage keeps its last payload.
// -----------------------------------------------------------------------------
module pa_fmau_stage_vld #(
    parameter int unsigned PLD_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             flush_i,
    input  logic [PLD_W-1:0] pld_i,
    output logic             vld_o,
    output logic [PLD_W-1:0] pld_o
);

    logic             vld_d;
    logic             vld_q;
    logic [PLD_W-1:0] pld_d;
    logic [PLD_W-1:0] pld_q;

    // Next-state for valid and payload
    always_comb begin
        vld_d = vld_q;
        pld_d = pld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d = 1'b1;
            pld_d = pld_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Stage state registers
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            vld_q <= 1'b0;
            pld_q <= {PLD_W{1'b0}};
        end else begin
            vld_q <= vld_d;
            pld_q <= pld_d;
        end
    end

    assign vld_o = vld_q;
    assign pld_o = pld_q;

endmodule

// File: rtl/pa_fmau_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pa_fmau_pipe_ctrl
// Pipeline controller for the single-precision FMAU datapath. Accepts issue
// from IDU, tracks EX2/EX3 occupancy, applies WB back-pressure and RTU flush,
// and generates pipe-down strobes, data-clock gate enables and the post-reset
// warm-up strobe that initialises the non-reset datapath flops.
// Ports:
//   forever_cpuclk / cpurst_b        clock / async active-low reset
//   idu_fmau_ex1_sel/_mac/_tag       issue valid, MAC flag, destination tag
//   fmau_idu_ex1_ready               FMAU can accept issue this cycle
//   rtu_fmau_flush                   kill all in-flight ops
//   wb_fmau_ex3_grant                WB accepts the EX3 result this cycle
//   ctrl_dp_ex1/ex2_inst_pipe_down   datapath stage register loads
//   ctrl_xx_ex1_warm_up              warm-up load strobe to all stages
//   fmau_ex2/ex3_data_clk_en         data clock gate enables
//   ex2_mac                          EX2 op is fused mult-add
//   fmau_wb_ex3_vld/_tag             EX3 result valid and tag to WB
//   fmau_xx_no_op                    pipe empty and not warming up
// -----------------------------------------------------------------------------
module pa_fmau_pipe_ctrl
    import pa_fmau_pipe_ctrl_pkg::*;
#(
    parameter int unsigned WARM_UP_CYCLES = 2,
    parameter int unsigned TAG_WIDTH      = 5
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 idu_fmau_ex1_sel,
    input  logic                 idu_fmau_ex1_mac,
    input  logic [TAG_WIDTH-1:0] idu_fmau_ex1_tag,
    output logic                 fmau_idu_ex1_ready,
    input  logic                 rtu_fmau_flush,
    input  logic                 wb_fmau_ex3_grant,
    output logic                 ctrl_dp_ex1_inst_pipe_down,
    output logic                 ctrl_dp_ex2_inst_pipe_down,
    output logic                 ctrl_xx_ex1_warm_up,
    output logic                 fmau_ex2_data_clk_en,
    output logic                 fmau_ex3_data_clk_en,
    output logic                 ex2_mac,
    output logic                 fmau_wb_ex3_vld,
    output logic [TAG_WIDTH-1:0] fmau_wb_ex3_tag,
    output logic                 fmau_xx_no_op
);

    localparam logic [FMAU_WARM_CNT_W-1:0] WARM_INIT = FMAU_WARM_CNT_W'(WARM_UP_CYCLES - 1);

    fmau_state_e                state_d;
    fmau_state_e                state_q;
    logic [FMAU_WARM_CNT_W-1:0] warm_cnt_d;
    logic [FMAU_WARM_CNT_W-1:0] warm_cnt_q;

    logic                 warm_up_s;
    logic                 run_s;
    logic                 ex2_vld_s;
    logic                 ex3_vld_s;
    logic                 ex3_free_s;
    logic                 ex2_free_s;
    logic                 ready_s;
    logic                 ex1_pd_s;
    logic                 ex2_pd_s;
    logic                 ex3_drain_s;
    logic [TAG_WIDTH:0]   ex2_pld_s;
    logic [TAG_WIDTH-1:0] ex3_tag_s;

    // Warm-up FSM: count down in WARM, then RUN until the next reset
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        case (state_q)
            FMAU_WARM: begin
                if (warm_cnt_q == {FMAU_WARM_CNT_W{1'b0}}) begin
                    state_d = FMAU_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q - FMAU_WARM_CNT_W'(1);
                end
            end
            FMAU_RUN: begin
                state_d = FMAU_RUN;
            end
            default: begin
                state_d    = FMAU_WARM;
                warm_cnt_d = WARM_INIT;
            end
        endcase
    end

    // FSM state and warm-up counter registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= FMAU_WARM;
            warm_cnt_q <= WARM_INIT;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign warm_up_s = (state_q == FMAU_WARM);
    assign run_s     = (state_q == FMAU_RUN);

    // A stage is free if empty or if its occupant leaves this cycle, which
    // lets a new op follow a granted one without a bubble.
    assign ex3_free_s  = !ex3_vld_s || wb_fmau_ex3_grant;
    assign ex2_free_s  = !ex2_vld_s || ex3_free_s;
    assign ready_s     = run_s && ex2_free_s && !rtu_fmau_flush;
    assign ex1_pd_s    = idu_fmau_ex1_sel && ready_s;
    assign ex2_pd_s    = ex2_vld_s && ex3_free_s && !rtu_fmau_flush;
    assign ex3_drain_s = ex3_vld_s && wb_fmau_ex3_grant;

    pa_fmau_stage_vld #(
        .PLD_W (TAG_WIDTH + 1)
    ) u_ex2_stage (
        .clk_i   (forever_cpuclk),
        .rst_b_i (cpurst_b),
        .load_i  (ex1_pd_s),
        .drain_i (ex2_pd_s),
        .flush_i (rtu_fmau_flush),
        .pld_i   ({idu_fmau_ex1_mac, idu_fmau_ex1_tag}),
        .vld_o   (ex2_vld_s),
        .pld_o   (ex2_pld_s)
    );

    pa_fmau_stage_vld #(
        .PLD_W (TAG_WIDTH)
    ) u_ex3_stage (
        .clk_i   (forever_cpuclk),
        .rst_b_i (cpurst_b),
        .load_i  (ex2_pd_s),
        .drain_i (ex3_drain_s),
        .flush_i (rtu_fmau_flush),
        .pld_i   (ex2_pld_s[TAG_WIDTH-1:0]),
        .vld_o   (ex3_vld_s),
        .pld_o   (ex3_tag_s)
    );

    assign fmau_idu_ex1_ready         = ready_s;
    assign ctrl_dp_ex1_inst_pipe_down = ex1_pd_s;
    assign ctrl_dp_ex2_inst_pipe_down = ex2_pd_s;
    assign ctrl_xx_ex1_warm_up        = warm_up_s;
    // Warm-up clocks every datapath stage so the non-reset flops settle
    assign fmau_ex2_data_clk_en       = ex1_pd_s || warm_up_s;
    assign fmau_ex3_data_clk_en       = ex2_pd_s || warm_up_s;
    assign ex2_mac                    = ex2_pld_s[TAG_WIDTH];
    assign fmau_wb_ex3_vld            = ex3_vld_s;
    assign fmau_wb_ex3_tag            = ex3_tag_s;
    assign fmau_xx_no_op              = run_s && !ex2_vld_s && !ex3_vld_s;

endmodule

// File: tb/tb_pa_fmau_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pa_fmau_pipe_ctrl
// Directed bench for pa_fmau_pipe_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pa_fmau_pipe_ctrl;

    localparam int unsigned TW = 5;

    logic          clk;
    logic          rst_b;
    logic          sel;
    logic          mac;
    logic [TW-1:0] tag;
    logic          flush;
    logic          grant;
    logic          ready;
    logic          ex1_pd;
    logic          ex2_pd;
    logic          warm_up;
    logic          ex2_clk_en;
    logic          ex3_clk_en;
    logic          ex2_mac_o;
    logic          wb_vld;
    logic [TW-1:0] wb_tag;
    logic          no_op;

    int checks;
    int errors;

    pa_fmau_pipe_ctrl #(
        .WARM_UP_CYCLES (2),
        .TAG_WIDTH      (TW)
    ) dut (
        .forever_cpuclk             (clk),
        .cpurst_b                   (rst_b),
        .idu_fmau_ex1_sel           (sel),
        .idu_fmau_ex1_mac           (mac),
        .idu_fmau_ex1_tag           (tag),
        .fmau_idu_ex1_ready         (ready),
        .rtu_fmau_flush             (flush),
        .wb_fmau_ex3_grant          (grant),
        .ctrl_dp_ex1_inst_pipe_down (ex1_pd),
        .ctrl_dp_ex2_inst_pipe_down (ex2_pd),
        .ctrl_xx_ex1_warm_up        (warm_up),
        .fmau_ex2_data_clk_en       (ex2_clk_en),
        .fmau_ex3_data_clk_en       (ex3_clk_en),
        .ex2_mac                    (ex2_mac_o),
        .fmau_wb_ex3_vld            (wb_vld),
        .fmau_wb_ex3_tag            (wb_tag),
        .fmau_xx_no_op              (no_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // advance to next falling edge and let combinational outputs settle
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic m, input logic [TW-1:0] t);
        sel = s;
        mac = m;
        tag = t;
    endtask

    // pipeline outputs: wb valid, wb tag, no_op
    task automatic chk_wb(input string name, input logic v, input logic [TW-1:0] t, input logic n);
        chk({name, "_wb_vld"}, {7'd0, wb_vld}, {7'd0, v});
        if (v) chk({name, "_wb_tag"}, {3'd0, wb_tag}, {3'd0, t});
        chk({name, "_no_op"}, {7'd0, no_op}, {7'd0, n});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        sel    = 1'b0;
        mac    = 1'b0;
        tag    = 5'd0;
        flush  = 1'b0;
        grant  = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_warm_up", {7'd0, warm_up}, 8'd1);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd3);
        chk("rst_pd", {6'd0, ex1_pd, ex2_pd}, 8'd0);
        chk("rst_ex2_mac", {7'd0, ex2_mac_o}, 8'd0);
        chk("rst_wb_tag", {3'd0, wb_tag}, 8'd0);
        chk_wb("rst", 1'b0, 5'd0, 1'b0);

        // ---- warm-up: issue during WARM is ignored ----
        @(negedge clk);
        rst_b = 1'b1;
        issue(1'b1, 1'b1, 5'd9);
        #1;
        chk("warm1_warm_up", {7'd0, warm_up}, 8'd1);
        chk("warm1_ready", {7'd0, ready}, 8'd0);
        chk("warm1_ex1_pd", {7'd0, ex1_pd}, 8'd0);
        cyc();
        chk("warm2_warm_up", {7'd0, warm_up}, 8'd1);
        chk("warm2_ready", {7'd0, ready}, 8'd0);
        issue(1'b0, 1'b0, 5'd0);
        cyc();
        chk("run_warm_up", {7'd0, warm_up}, 8'd0);
        chk("run_ready", {7'd0, ready}, 8'd1);
        chk("run_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd0);
        chk_wb("run", 1'b0, 5'd0, 1'b1);

        // ---- back-to-back issue 1,2,3 with grant ----
        grant = 1'b1;
        issue(1'b1, 1'b0, 5'd1);
        #1;
        chk("b2b0_ex1_pd", {7'd0, ex1_pd}, 8'd1);
        chk("b2b0_ex2_clk_en", {7'd0, ex2_clk_en}, 8'd1);
        cyc();
        issue(1'b1, 1'b0, 5'd2);
        #1;
        chk("b2b1_pd", {6'd0, ex1_pd, ex2_pd}, 8'd3);
        chk_wb("b2b1", 1'b0, 5'd0, 1'b0);
        cyc();
        issue(1'b1, 1'b0, 5'd3);
        #1;
        chk_wb("b2b2", 1'b1, 5'd1, 1'b0);
        cyc();
        issue(1'b0, 1'b0, 5'd0);
        #1;
        chk_wb("b2b3", 1'b1, 5'd2, 1'b0);
        cyc();
        chk_wb("b2b4", 1'b1, 5'd3, 1'b0);
        cyc();
        chk_wb("b2b5", 1'b0, 5'd0, 1'b1);

        // ---- stall: grant low 3 cycles with EX2/EX3 full ----
        grant = 1'b0;
        issue(1'b1, 1'b1, 5'd4);
        cyc();
        issue(1'b1, 1'b0, 5'd5);
        #1;
        chk("st1_ready", {7'd0, ready}, 8'd1);
        chk("st1_ex2_pd", {7'd0, ex2_pd}, 8'd1);
        chk("st1_ex2_mac", {7'd0, ex2_mac_o}, 8'd1);
        cyc();
        issue(1'b1, 1'b0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_ready", {7'd0, ready}, 8'd0);
            chk("st_pd", {6'd0, ex1_pd, ex2_pd}, 8'd0);
            chk("st_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd0);
            chk("st_ex2_mac", {7'd0, ex2_mac_o}, 8'd0);
            chk_wb("st", 1'b1, 5'd4, 1'b0);
            cyc();
        end
        grant = 1'b1;
        #1;
        chk("res0_ready", {7'd0, ready}, 8'd1);
        chk("res0_pd", {6'd0, ex1_pd, ex2_pd}, 8'd3);
        chk_wb("res0", 1'b1, 5'd4, 1'b0);
        cyc();
        issue(1'b0, 1'b0, 5'd0);
        #1;
        chk_wb("res1", 1'b1, 5'd5, 1'b0);
        cyc();
        chk_wb("res2", 1'b1, 5'd6, 1'b0);
        cyc();
        chk_wb("res3", 1'b0, 5'd0, 1'b1);

        // ---- flush with EX2/EX3 valid and grant high ----
        issue(1'b1, 1'b0, 5'd7);
        cyc();
        issue(1'b1, 1'b0, 5'd8);
        cyc();
        issue(1'b1, 1'b0, 5'd9);
        flush = 1'b1;
        #1;
        chk("fl_ready", {7'd0, ready}, 8'd0);
        chk("fl_pd", {6'd0, ex1_pd, ex2_pd}, 8'd0);
        chk_wb("fl", 1'b1, 5'd7, 1'b0);
        cyc();
        flush = 1'b0;
        issue(1'b0, 1'b0, 5'd0);
        #1;
        chk_wb("fl_after", 1'b0, 5'd0, 1'b1);

        // ---- MAC then non-MAC: ex2_mac alignment and clock enables ----
        issue(1'b1, 1'b1, 5'd10);
        cyc();
        issue(1'b1, 1'b0, 5'd11);
        #1;
        chk("mac1_ex2_mac", {7'd0, ex2_mac_o}, 8'd1);
        chk("mac1_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd3);
        cyc();
        issue(1'b0, 1'b0, 5'd0);
        #1;
        chk("mac2_ex2_mac", {7'd0, ex2_mac_o}, 8'd0);
        chk("mac2_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd1);
        chk_wb("mac2", 1'b1, 5'd10, 1'b0);
        cyc();
        chk("mac3_clk_en", {6'd0, ex2_clk_en, ex3_clk_en}, 8'd0);
        chk_wb("mac3", 1'b1, 5'd11, 1'b0);
        cyc();

        // ---- async reset while EX3 stalled ----
        grant = 1'b0;
        issue(1'b1, 1'b0, 5'd12);
        cyc();
        issue(1'b0, 1'b0, 5'd0);
        cyc();
        chk_wb("pre_rst", 1'b1, 5'd12, 1'b0);
        rst_b = 1'b0;
        #1;
        chk("mrst_warm_up", {7'd0, warm_up}, 8'd1);
        chk("mrst_ready", {7'd0, ready}, 8'd0);
        chk("mrst_wb_tag", {3'd0, wb_tag}, 8'd0);
        chk_wb("mrst", 1'b0, 5'd0, 1'b0);
        cyc();
        rst_b = 1'b1;
        flush = 1'b1;
        #1;
        chk("rw1_warm_up", {7'd0, warm_up}, 8'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("rw2_warm_up", {7'd0, warm_up}, 8'd1);
        chk("rw2_ready", {7'd0, ready}, 8'd0);
        cyc();
        chk("rw3_warm_up", {7'd0, warm_up}, 8'd0);
        chk("rw3_ready", {7'd0, ready}, 8'd1);
        chk_wb("rw3", 1'b0, 5'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
